issue_stage: RTL

In-order issue stage that receives the registered instruction bundle from the decode stage and dispatches it to one of three functional units: ALU, shifter or memory. It reads operands from the register file with the decode-latched source addresses. A per-register pending-write scoreboard and a writeback-port reservation ring detect RAW and structural hazards. On a hazard it asserts `iss_stall` to freeze decode and sends a bubble downstream. It sits between decode and the execute units.

---
 rtl/issue_pkg.sv | 50 +++++
 rtl/issue_if.sv | 74 +++++++
 rtl/issue_scoreboard.sv | 66 ++++++
 rtl/issue_stage.sv | 116 +++++++++++
 4 files changed

// File: rtl/issue_pkg.sv
// Shared types and constants for the in-order issue stage.
package issue_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned OP_W     = 6;
    localparam int unsigned ALUOP_W  = 3;
    localparam int unsigned SHOP_W   = 2;

    typedef enum logic [1:0] {
        FU_ALU   = 2'd0,
        FU_SHIFT = 2'd1,
        FU_MEM   = 2'd2
    } fu_t;

    localparam logic [OP_W-1:0] OP_J   = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL = 6'h03;
    localparam logic [OP_W-1:0] OP_LUI = 6'h0F;

    // Registered bundle handed to the execute units.
    typedef struct packed {
        logic               alu_valid;
        logic               shift_valid;
        logic               mem_valid;
        logic [DATA_W-1:0]  dataa;
        logic [DATA_W-1:0]  datab;
        logic [DATA_W-1:0]  imedext;
        logic [REG_AW-1:0]  regdest;
        logic [ALUOP_W-1:0] aluop;
        logic [SHOP_W-1:0]  shiftop;
        logic               writereg;
        logic               writeov;
        logic               selimregb;
        logic               unsig;
        logic               readmem;
        logic               writemem;
        logic               selwsource;
    } ex_bundle_t;

    function automatic int unsigned fu_latency(fu_t fu, int unsigned alu_lat,
                                               int unsigned shift_lat, int unsigned mem_lat);
        case (fu)
            FU_MEM:   return mem_lat;
            FU_SHIFT: return shift_lat;
            default:  return alu_lat;
        endcase
    endfunction

endpackage

// File: rtl/issue_if.sv
// Decode bundle in, register-file read port, and execute bundle out of the issue stage.
interface issue_if;
    import issue_pkg::*;

    logic [OP_W-1:0]    id_iss_op;
    logic [OP_W-1:0]    id_iss_funct;
    logic [REG_AW-1:0]  id_iss_addra;
    logic [REG_AW-1:0]  id_iss_addrb;
    logic [REG_AW-1:0]  id_iss_regdest;
    logic               id_iss_writereg;
    logic               id_iss_writeov;
    logic               id_iss_selregdest;
    logic               id_iss_selimregb;
    logic               id_iss_selalushift;
    logic               id_iss_unsig;
    logic               id_iss_readmem;
    logic               id_iss_writemem;
    logic               id_iss_selwsource;
    logic [ALUOP_W-1:0] id_iss_aluop;
    logic [SHOP_W-1:0]  id_iss_shiftop;
    logic [DATA_W-1:0]  id_iss_imedext;

    logic               iss_stall;
    logic [REG_AW-1:0]  iss_reg_addra;
    logic [REG_AW-1:0]  iss_reg_addrb;
    logic [DATA_W-1:0]  reg_iss_dataa;
    logic [DATA_W-1:0]  reg_iss_datab;

    logic               iss_ex_alu_valid;
    logic               iss_ex_shift_valid;
    logic               iss_ex_mem_valid;
    logic [DATA_W-1:0]  iss_ex_dataa;
    logic [DATA_W-1:0]  iss_ex_datab;
    logic [DATA_W-1:0]  iss_ex_imedext;
    logic [REG_AW-1:0]  iss_ex_regdest;
    logic [ALUOP_W-1:0] iss_ex_aluop;
    logic [SHOP_W-1:0]  iss_ex_shiftop;
    logic               iss_ex_writereg;
    logic               iss_ex_writeov;
    logic               iss_ex_selimregb;
    logic               iss_ex_unsig;
    logic               iss_ex_readmem;
    logic               iss_ex_writemem;
    logic               iss_ex_selwsource;

    modport master (
        output id_iss_op, id_iss_funct, id_iss_addra, id_iss_addrb, id_iss_regdest,
               id_iss_writereg, id_iss_writeov, id_iss_selregdest, id_iss_selimregb,
               id_iss_selalushift, id_iss_unsig, id_iss_readmem, id_iss_writemem,
               id_iss_selwsource, id_iss_aluop, id_iss_shiftop, id_iss_imedext,
               reg_iss_dataa, reg_iss_datab,
        input  iss_stall, iss_reg_addra, iss_reg_addrb,
               iss_ex_alu_valid, iss_ex_shift_valid, iss_ex_mem_valid,
               iss_ex_dataa, iss_ex_datab, iss_ex_imedext, iss_ex_regdest,
               iss_ex_aluop, iss_ex_shiftop, iss_ex_writereg, iss_ex_writeov,
               iss_ex_selimregb, iss_ex_unsig, iss_ex_readmem, iss_ex_writemem,
               iss_ex_selwsource
    );

    modport slave (
        input  id_iss_op, id_iss_funct, id_iss_addra, id_iss_addrb, id_iss_regdest,
               id_iss_writereg, id_iss_writeov, id_iss_selregdest, id_iss_selimregb,
               id_iss_selalushift, id_iss_unsig, id_iss_readmem, id_iss_writemem,
               id_iss_selwsource, id_iss_aluop, id_iss_shiftop, id_iss_imedext,
               reg_iss_dataa, reg_iss_datab,
        output iss_stall, iss_reg_addra, iss_reg_addrb,
               iss_ex_alu_valid, iss_ex_shift_valid, iss_ex_mem_valid,
               iss_ex_dataa, iss_ex_datab, iss_ex_imedext, iss_ex_regdest,
               iss_ex_aluop, iss_ex_shiftop, iss_ex_writereg, iss_ex_writeov,
               iss_ex_selimregb, iss_ex_unsig, iss_ex_readmem, iss_ex_writemem,
               iss_ex_selwsource
    );

endinterface

// File: rtl/issue_scoreboard.sv
// Pending-write counters per register plus the writeback-slot reservation ring;
// flags RAW, WAW and writeback-port hazards for the bundle currently in decode.
module issue_scoreboard
    import issue_pkg::*;
#(
    parameter int unsigned MEM_LAT = 3,
    parameter int unsigned CNT_W   = $clog2(MEM_LAT + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic              rs_used,
    input  logic [REG_AW-1:0] rt_addr,
    input  logic              rt_used,
    input  logic [REG_AW-1:0] rd_addr,
    input  logic [CNT_W-1:0]  lat,
    input  logic              writereg,
    input  logic              issue,
    output logic              hazard
);

    logic [CNT_W-1:0]   pend_q [NUM_REGS];
    logic [MEM_LAT-1:0] wbres_q;
    logic [MEM_LAT-1:0] wbres_d;
    logic [MEM_LAT:0]   wb_ext_c;
    logic [MEM_LAT:0]   set_ext_c;
    logic               raw_c;
    logic               struct_c;
    logic               waw_c;

    // Bit `lat` of the unshifted ring is the slot this bundle would land in; the
    // extra zero top bit means a max-latency writer can never collide.
    always_comb begin
        wb_ext_c  = {1'b0, wbres_q};
        set_ext_c = (MEM_LAT + 1)'(1) << lat;
        raw_c     = (rs_used && (rs_addr != '0) && (pend_q[rs_addr] != '0)) ||
                    (rt_used && (rt_addr != '0) && (pend_q[rt_addr] != '0));
        struct_c  = writereg && wb_ext_c[lat];
        waw_c     = writereg && (rd_addr != '0) && (pend_q[rd_addr] > lat);
        hazard    = raw_c || struct_c || waw_c;
        wbres_d   = wbres_q >> 1;
        if (issue && writereg) begin
            wbres_d = wbres_d | set_ext_c[MEM_LAT:1];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wbres_q <= '0;
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                pend_q[r] <= '0;
            end
        end else begin
            wbres_q   <= wbres_d;
            pend_q[0] <= '0;
            for (int unsigned r = 1; r < NUM_REGS; r++) begin
                if (issue && writereg && (rd_addr == REG_AW'(r))) begin
                    pend_q[r] <= lat;
                end else if (pend_q[r] != '0) begin
                    pend_q[r] <= pend_q[r] - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/issue_stage.sv
// In-order issue stage: picks the functional unit, checks hazards against the
// scoreboard, and registers the operand bundle for execute or sends a bubble.
module issue_stage
    import issue_pkg::*;
#(
    parameter int unsigned ALU_LAT   = 1,
    parameter int unsigned SHIFT_LAT = 1,
    parameter int unsigned MEM_LAT   = 3
) (
    input  logic  clock,
    input  logic  reset,
    issue_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(MEM_LAT + 1);

    fu_t              fu_c;
    logic [CNT_W-1:0] lat_c;
    logic             rs_used_c;
    logic             rt_used_c;
    logic             hazard_c;
    logic             issue_c;
    ex_bundle_t       ex_q;
    ex_bundle_t       ex_d;
    logic             unused_funct;

    assign unused_funct = ^bus.id_iss_funct;

    always_comb begin
        fu_c = FU_ALU;
        if (bus.id_iss_readmem || bus.id_iss_writemem) begin
            fu_c = FU_MEM;
        end else if (bus.id_iss_selalushift) begin
            fu_c = FU_SHIFT;
        end
    end

    assign lat_c     = CNT_W'(fu_latency(fu_c, ALU_LAT, SHIFT_LAT, MEM_LAT));
    assign rs_used_c = !((bus.id_iss_op == OP_J) || (bus.id_iss_op == OP_JAL) ||
                         (bus.id_iss_op == OP_LUI));
    assign rt_used_c = bus.id_iss_selregdest || bus.id_iss_writemem;

    issue_scoreboard #(
        .MEM_LAT (MEM_LAT),
        .CNT_W   (CNT_W)
    ) u_scoreboard (
        .clock    (clock),
        .reset    (reset),
        .rs_addr  (bus.id_iss_addra),
        .rs_used  (rs_used_c),
        .rt_addr  (bus.id_iss_addrb),
        .rt_used  (rt_used_c),
        .rd_addr  (bus.id_iss_regdest),
        .lat      (lat_c),
        .writereg (bus.id_iss_writereg),
        .issue    (issue_c),
        .hazard   (hazard_c)
    );

    assign issue_c           = !hazard_c;
    assign bus.iss_stall     = hazard_c;
    assign bus.iss_reg_addra = bus.id_iss_addra;
    assign bus.iss_reg_addrb = bus.id_iss_addrb;

    // A stall drops the valids but leaves the payload untouched.
    always_comb begin
        ex_d             = ex_q;
        ex_d.alu_valid   = 1'b0;
        ex_d.shift_valid = 1'b0;
        ex_d.mem_valid   = 1'b0;
        if (issue_c) begin
            ex_d.alu_valid   = (fu_c == FU_ALU);
            ex_d.shift_valid = (fu_c == FU_SHIFT);
            ex_d.mem_valid   = (fu_c == FU_MEM);
            ex_d.dataa       = bus.reg_iss_dataa;
            ex_d.datab       = bus.reg_iss_datab;
            ex_d.imedext     = bus.id_iss_imedext;
            ex_d.regdest     = bus.id_iss_regdest;
            ex_d.aluop       = bus.id_iss_aluop;
            ex_d.shiftop     = bus.id_iss_shiftop;
            ex_d.writereg    = bus.id_iss_writereg;
            ex_d.writeov     = bus.id_iss_writeov;
            ex_d.selimregb   = bus.id_iss_selimregb;
            ex_d.unsig       = bus.id_iss_unsig;
            ex_d.readmem     = bus.id_iss_readmem;
            ex_d.writemem    = bus.id_iss_writemem;
            ex_d.selwsource  = bus.id_iss_selwsource;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign bus.iss_ex_alu_valid   = ex_q.alu_valid;
    assign bus.iss_ex_shift_valid = ex_q.shift_valid;
    assign bus.iss_ex_mem_valid   = ex_q.mem_valid;
    assign bus.iss_ex_dataa       = ex_q.dataa;
    assign bus.iss_ex_datab       = ex_q.datab;
    assign bus.iss_ex_imedext     = ex_q.imedext;
    assign bus.iss_ex_regdest     = ex_q.regdest;
    assign bus.iss_ex_aluop       = ex_q.aluop;
    assign bus.iss_ex_shiftop     = ex_q.shiftop;
    assign bus.iss_ex_writereg    = ex_q.writereg;
    assign bus.iss_ex_writeov     = ex_q.writeov;
    assign bus.iss_ex_selimregb   = ex_q.selimregb;
    assign bus.iss_ex_unsig       = ex_q.unsig;
    assign bus.iss_ex_readmem     = ex_q.readmem;
    assign bus.iss_ex_writemem    = ex_q.writemem;
    assign bus.iss_ex_selwsource  = ex_q.selwsource;

endmodule
